// File: rtl/alu_pkg.sv
// Shared ALU definitions: R-type funct codes, instruction field positions and
// the issue-side state encoding.
package alu_pkg;

  localparam logic [5:0] OPCODE_RTYPE = 6'b000000;

  localparam logic [5:0] FUNCT_SLL = 6'b000000;
  localparam logic [5:0] FUNCT_SRL = 6'b000010;
  localparam logic [5:0] FUNCT_SRA = 6'b000011;
  localparam logic [5:0] FUNCT_JR  = 6'b001000;
  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_XOR = 6'b100110;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;
  localparam int RS_MSB     = 25;
  localparam int RS_LSB     = 21;
  localparam int RT_MSB     = 20;
  localparam int RT_LSB     = 16;
  localparam int RD_MSB     = 15;
  localparam int RD_LSB     = 11;
  localparam int SA_MSB     = 10;
  localparam int SA_LSB     = 6;
  localparam int FUNCT_MSB  = 5;
  localparam int FUNCT_LSB  = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_WB,
    ST_JR,
    ST_ERR
  } state_t;

  function automatic logic funct_supported(input logic [5:0] f);
    case (f)
      FUNCT_SLL, FUNCT_SRL, FUNCT_SRA, FUNCT_JR, FUNCT_ADD,
      FUNCT_SUB, FUNCT_AND, FUNCT_OR, FUNCT_XOR, FUNCT_SLT: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_issue_r_decode.sv
// Combinational R-type decoder: field slices plus legality and JR detection.
module r_decode
  import alu_pkg::*;
(
  input  logic [31:0] instr,
  output logic        opcode_ok,
  output logic        funct_ok,
  output logic        is_jr,
  output logic [5:0]  funct,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [4:0]  sa
);

  logic [5:0] opcode;

  assign opcode    = instr[OPCODE_MSB:OPCODE_LSB];
  assign funct     = instr[FUNCT_MSB:FUNCT_LSB];
  assign rs        = instr[RS_MSB:RS_LSB];
  assign rt        = instr[RT_MSB:RT_LSB];
  assign rd        = instr[RD_MSB:RD_LSB];
  assign sa        = instr[SA_MSB:SA_LSB];

  assign opcode_ok = (opcode == OPCODE_RTYPE);
  assign funct_ok  = funct_supported(funct);
  assign is_jr     = (funct == FUNCT_JR);

endmodule

// File: rtl/alu_issue.sv
// ALU handshake initiator: latches an R-type word, issues it to the ALU, waits
// (bounded) for completion and emits writeback, JR redirect or error pulses.
module alu_issue
  import alu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        CLK,
  input  logic        RSTN,
  input  logic [31:0] instr,
  input  logic        instr_valid,
  output logic        instr_ready,
  output logic [5:0]  funct,
  output logic        alu_enable,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  sa,
  input  logic [4:0]  alu_rd,
  input  logic        alu_valid,
  output logic        wb_en,
  output logic [4:0]  wb_addr,
  output logic        rd_mismatch,
  output logic        jr_req,
  output logic [4:0]  jr_reg,
  output logic        illegal,
  output logic        timeout,
  output logic        busy
);

  localparam int              CW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          accept;
  logic          alu_enable_nx, wb_en_nx, rd_mismatch_nx, jr_req_nx;
  logic          illegal_nx, timeout_nx;

  logic          dec_opcode_ok, dec_funct_ok, dec_is_jr;
  logic [5:0]    dec_funct;
  logic [4:0]    dec_rs, dec_rt, dec_rd, dec_sa;

  r_decode u_decode (
    .instr     (instr),
    .opcode_ok (dec_opcode_ok),
    .funct_ok  (dec_funct_ok),
    .is_jr     (dec_is_jr),
    .funct     (dec_funct),
    .rs        (dec_rs),
    .rt        (dec_rt),
    .rd        (dec_rd),
    .sa        (dec_sa)
  );

  assign instr_ready = (state == ST_IDLE);
  assign busy        = (state != ST_IDLE);
  assign accept      = instr_valid & instr_ready;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (!dec_opcode_ok || !dec_funct_ok) state_nx = ST_ERR;
          else if (dec_is_jr)                  state_nx = ST_JR;
          else                                 state_nx = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cnt_nx   = '0;
        state_nx = ST_WAIT;
      end
      ST_WAIT: begin
        // A completion in the final allowed cycle still counts.
        if (alu_valid)             state_nx = ST_WB;
        else if (cnt == CNT_LAST)  state_nx = ST_ERR;
        else                       cnt_nx   = cnt + CW'(1);
      end
      ST_WB, ST_JR, ST_ERR: state_nx = ST_IDLE;
      default:              state_nx = ST_IDLE;
    endcase

    // Pulse outputs are registered, so they are derived from the transition.
    alu_enable_nx  = (state_nx == ST_ISSUE);
    wb_en_nx       = (state == ST_WAIT) && alu_valid && (wb_addr != 5'd0);
    rd_mismatch_nx = (state == ST_WAIT) && alu_valid && (alu_rd != wb_addr);
    jr_req_nx      = (state_nx == ST_JR);
    illegal_nx     = (state == ST_IDLE) && (state_nx == ST_ERR);
    timeout_nx     = (state == ST_WAIT) && (state_nx == ST_ERR);
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      funct       <= '0;
      rs          <= '0;
      rt          <= '0;
      sa          <= '0;
      wb_addr     <= '0;
      jr_reg      <= '0;
      alu_enable  <= 1'b0;
      wb_en       <= 1'b0;
      rd_mismatch <= 1'b0;
      jr_req      <= 1'b0;
      illegal     <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      if (accept) begin
        funct   <= dec_funct;
        rs      <= dec_rs;
        rt      <= dec_rt;
        sa      <= dec_sa;
        wb_addr <= dec_rd;
        jr_reg  <= dec_rs;
      end
      alu_enable  <= alu_enable_nx;
      wb_en       <= wb_en_nx;
      rd_mismatch <= rd_mismatch_nx;
      jr_req      <= jr_req_nx;
      illegal     <= illegal_nx;
      timeout     <= timeout_nx;
    end
  end

endmodule

// File: tb/tb_alu_issue.sv
// Scoreboard bench for alu_issue: the driver pushes expected output events from
// a behavioural model, a negedge monitor pops and compares them.
module tb_alu_issue;

  localparam int TO = 4;

  logic        CLK = 1'b0;
  logic        RSTN = 1'b0;
  logic [31:0] instr = '0;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [5:0]  funct;
  logic        alu_enable;
  logic [4:0]  rs, rt, sa;
  logic [4:0]  alu_rd = '0;
  logic        alu_valid = 1'b0;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic        rd_mismatch;
  logic        jr_req;
  logic [4:0]  jr_reg;
  logic        illegal;
  logic        timeout;
  logic        busy;

  alu_issue #(.TIMEOUT_CYCLES(TO)) dut (
    .CLK(CLK), .RSTN(RSTN), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .funct(funct), .alu_enable(alu_enable),
    .rs(rs), .rt(rt), .sa(sa), .alu_rd(alu_rd), .alu_valid(alu_valid),
    .wb_en(wb_en), .wb_addr(wb_addr), .rd_mismatch(rd_mismatch),
    .jr_req(jr_req), .jr_reg(jr_reg), .illegal(illegal), .timeout(timeout),
    .busy(busy)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  // flags = {alu_enable, wb_en, rd_mismatch, jr_req, illegal, timeout}
  typedef struct {
    int         cyc;
    logic [5:0] flags;
    logic [5:0] funct;
    logic [4:0] rs, rt, sa, addr, jr;
  } ev_t;

  ev_t q[$];

  function automatic void push_ev(int c, logic [5:0] fl, logic [5:0] fn,
                                  logic [4:0] r_s, logic [4:0] r_t, logic [4:0] s_a,
                                  logic [4:0] ad, logic [4:0] j);
    ev_t e;
    e.cyc = c; e.flags = fl; e.funct = fn; e.rs = r_s; e.rt = r_t; e.sa = s_a;
    e.addr = ad; e.jr = j;
    q.push_back(e);
  endfunction

  // Monitor
  always @(negedge CLK) begin : mon
    logic [5:0] fl;
    ev_t        e;
    logic       ok;
    if (RSTN) begin
      fl = {alu_enable, wb_en, rd_mismatch, jr_req, illegal, timeout};
      while (q.size() > 0 && q[0].cyc < cyc) begin
        checks++; errors++;
        $display("FAIL missing_event cyc=%0d expected flags=%b, nothing seen", q[0].cyc, q[0].flags);
        void'(q.pop_front());
      end
      if (fl != 6'b0) begin
        checks++;
        if (q.size() == 0 || q[0].cyc != cyc) begin
          errors++;
          $display("FAIL unexpected_output cyc=%0d actual flags=%b required flags=000000", cyc, fl);
        end else begin
          e  = q.pop_front();
          ok = (fl == e.flags);
          if (e.flags[5]) ok = ok && funct == e.funct && rs == e.rs && rt == e.rt && sa == e.sa;
          if (e.flags[4]) ok = ok && wb_addr == e.addr;
          if (e.flags[2]) ok = ok && jr_reg == e.jr;
          if (!ok) begin
            errors++;
            $display("FAIL event cyc=%0d actual flags=%b funct=%h rs=%0d rt=%0d sa=%0d wb_addr=%0d jr_reg=%0d required flags=%b funct=%h rs=%0d rt=%0d sa=%0d wb_addr=%0d jr_reg=%0d",
                     cyc, fl, funct, rs, rt, sa, wb_addr, jr_reg,
                     e.flags, e.funct, e.rs, e.rt, e.sa, e.addr, e.jr);
          end
        end
      end
    end
  end

  function automatic logic [31:0] mk(logic [5:0] op, logic [4:0] r_s, logic [4:0] r_t,
                                     logic [4:0] r_d, logic [4:0] s_a, logic [5:0] fn);
    return {op, r_s, r_t, r_d, s_a, fn};
  endfunction

  function automatic logic is_legal_funct(logic [5:0] fn);
    return fn inside {6'h00, 6'h02, 6'h03, 6'h08, 6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h2a};
  endfunction

  task automatic wait_ready(output logic ok);
    ok = 1'b0;
    for (int n = 0; n < 30; n++) begin
      if (instr_ready) begin ok = 1'b1; break; end
      @(posedge CLK); #1;
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL wait_ready cyc=%0d instr_ready=0 required 1 within 30 cycles", cyc);
    end
  endtask

  // Issue one instruction; alu_valid is driven in cycle t+v_off (0 = never).
  task automatic run(input logic [31:0] ins, input int v_off, input logic [4:0] ard);
    logic       ok;
    int         t, v, exp_ready, got_ready;
    logic [5:0] op, fn;
    logic [4:0] i_rs, i_rt, i_rd, i_sa;
    logic       wb, mism;
    wait_ready(ok);
    if (!ok) return;
    op = ins[31:26]; i_rs = ins[25:21]; i_rt = ins[20:16];
    i_rd = ins[15:11]; i_sa = ins[10:6]; fn = ins[5:0];
    t = cyc;
    instr = ins; instr_valid = 1'b1;
    if (op != 6'd0 || !is_legal_funct(fn)) begin
      push_ev(t + 1, 6'b000010, 0, 0, 0, 0, 0, 0);
      exp_ready = t + 2;
    end else if (fn == 6'h08) begin
      push_ev(t + 1, 6'b000100, 0, 0, 0, 0, 0, i_rs);
      exp_ready = t + 2;
    end else begin
      push_ev(t + 1, 6'b100000, fn, i_rs, i_rt, i_sa, 0, 0);
      if (v_off >= 2 && v_off <= TO + 1) begin
        wb   = (i_rd != 5'd0);
        mism = (ard != i_rd);
        if (wb || mism) push_ev(t + v_off + 1, {1'b0, wb, mism, 3'b000}, 0, 0, 0, 0, i_rd, 0);
        exp_ready = t + v_off + 2;
      end else begin
        push_ev(t + TO + 2, 6'b000001, 0, 0, 0, 0, 0, 0);
        exp_ready = t + TO + 3;
      end
    end
    v = (v_off > 0) ? t + v_off : -1;
    got_ready = -1;
    for (int n = 0; n < 40; n++) begin
      @(posedge CLK); #1;
      instr_valid = 1'b0;
      alu_valid   = (cyc == v);
      alu_rd      = ard;
      if (got_ready < 0 && instr_ready) got_ready = cyc;
      if (got_ready >= 0 && cyc >= v) break;
    end
    if (alu_valid) begin
      @(posedge CLK); #1;
      alu_valid = 1'b0;
    end
    checks++;
    if (got_ready != exp_ready) begin
      errors++;
      $display("FAIL ready_cycle instr=%h actual=%0d required=%0d", ins, got_ready, exp_ready);
    end
  endtask

  task automatic check_all_zero(input string tag);
    checks++;
    if ({funct, rs, rt, sa, wb_addr, jr_reg, alu_enable, wb_en, rd_mismatch,
         jr_req, illegal, timeout, busy} != '0) begin
      errors++;
      $display("FAIL %s outputs not cleared: funct=%h rs=%0d rt=%0d sa=%0d wb_addr=%0d jr_reg=%0d en=%b wb=%b mm=%b jr=%b ill=%b to=%b busy=%b, required all 0",
               tag, funct, rs, rt, sa, wb_addr, jr_reg, alu_enable, wb_en, rd_mismatch,
               jr_req, illegal, timeout, busy);
    end
  endtask

  logic [5:0] legal_fn [10] = '{6'h00, 6'h02, 6'h03, 6'h08, 6'h20,
                                6'h22, 6'h24, 6'h25, 6'h26, 6'h2a};

  initial begin
    logic       ok;
    logic [5:0] r_op, r_fn;
    logic [4:0] r_rd, r_ard;
    #2;
    check_all_zero("reset_state");
    #20 RSTN = 1'b1;
    @(posedge CLK); #1;
    checks++;
    if (instr_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_reset actual=%b required=1", instr_ready);
    end

    run(mk(6'd0, 5'd3, 5'd4, 5'd5, 5'd0, 6'h20), 2, 5'd5);    // ADD
    run(mk(6'd0, 5'd31, 5'd0, 5'd0, 5'd0, 6'h08), 0, 5'd0);   // JR
    run(mk(6'h08, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20), 0, 5'd0);   // bad opcode
    run(mk(6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h3f), 0, 5'd0);    // bad funct
    run(mk(6'd0, 5'd1, 5'd2, 5'd9, 5'd0, 6'h22), 0, 5'd9);    // timeout
    run(mk(6'd0, 5'd1, 5'd2, 5'd9, 5'd0, 6'h22), 8, 5'd9);    // late valid in IDLE
    run(mk(6'd0, 5'd1, 5'd2, 5'd9, 5'd0, 6'h24), 1, 5'd9);    // valid in ISSUE ignored
    run(mk(6'd0, 5'd1, 5'd2, 5'd9, 5'd0, 6'h25), TO + 1, 5'd9); // last WAIT cycle
    run(mk(6'd0, 5'd0, 5'd6, 5'd0, 5'd4, 6'h00), 2, 5'd0);    // SLL rd=0
    run(mk(6'd0, 5'd2, 5'd3, 5'd7, 5'd0, 6'h20), 3, 5'd6);    // rd mismatch

    // Reset during WAIT
    wait_ready(ok);
    instr = mk(6'd0, 5'd3, 5'd4, 5'd5, 5'd0, 6'h20);
    instr_valid = 1'b1;
    push_ev(cyc + 1, 6'b100000, 6'h20, 5'd3, 5'd4, 5'd0, 0, 0);
    @(posedge CLK); #1; instr_valid = 1'b0;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    RSTN = 1'b0;
    #1;
    check_all_zero("reset_mid_wait");
    q.delete();
    #2 RSTN = 1'b1;
    #1;
    checks++;
    if (instr_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_abort actual=%b required=1", instr_ready);
    end
    @(posedge CLK); #1;
    run(mk(6'd0, 5'd3, 5'd4, 5'd5, 5'd0, 6'h20), 2, 5'd5);

    for (int i = 0; i < 150; i++) begin
      r_op  = ($urandom_range(7) == 0) ? 6'($urandom) : 6'd0;
      r_fn  = ($urandom_range(7) == 0) ? 6'($urandom) : legal_fn[$urandom_range(9)];
      r_rd  = ($urandom_range(3) == 0) ? 5'd0 : 5'($urandom);
      r_ard = ($urandom_range(3) == 0) ? 5'($urandom) : r_rd;
      run(mk(r_op, 5'($urandom), 5'($urandom), r_rd, 5'($urandom), r_fn),
          int'($urandom_range(8)), r_ard);
    end

    repeat (3) @(posedge CLK);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain actual=%0d pending required=0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
